// File: rtl/blc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : blc_pkg
//  Description : Shared types and constants for the binary-to-logarithmic
//                converter (BLC) and the LBC-side exponent adder.
//                Holds the default operand geometry, the fraction/exponent
//                widths and the packed stage-1 payload.
//  Contents    : BLC_LOG2_WIDTH, BLC_WIDTH  default operand geometry
//                FRAC_W, EXP_W              fraction / exponent widths
//                blc_stage_t                {sign, zero, exp, mag}
//                blc_norm_shift()           left shift that normalizes mag
//  Revision    : 1.0  initial release
// ============================================================================
package blc_pkg;

   localparam int unsigned BLC_LOG2_WIDTH = 4;
   localparam int unsigned BLC_WIDTH      = 1 << BLC_LOG2_WIDTH;
   localparam int unsigned FRAC_W         = BLC_WIDTH - 1;
   localparam int unsigned EXP_W          = BLC_LOG2_WIDTH;

   // Stage-1 payload: everything stage 2 needs to build the log form.
   typedef struct packed {
      logic             sign;
      logic             zero;
      logic [EXP_W-1:0] exp;
      logic [BLC_WIDTH-1:0] mag;
   } blc_stage_t;

   // Shift that moves the leading one at bit e up to bit WIDTH-1.
   // WIDTH-1 is all ones in EXP_W bits, so WIDTH-1-e is simply ~e.
   function automatic logic [EXP_W-1:0] blc_norm_shift(input logic [EXP_W-1:0] e);
      return ~e;
   endfunction

endpackage
`default_nettype wire

// File: rtl/blc_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : blc_pipe_if
//  Description : Input/output stream bundle of the BLC pipeline.
//  Signals     : in_valid, in_ready, data_in           operand stream
//                out_valid, out_ready                  result handshake
//                exp_out, frac_out, zero_out, sign_out result payload
//  Modports    : master  producer of operands / consumer of results
//                slave   the converter itself
//  Revision    : 1.0  initial release
// ============================================================================
interface blc_pipe_if
   import blc_pkg::*;
#(
   parameter int unsigned LOG2_WIDTH = BLC_LOG2_WIDTH,
   parameter int unsigned WIDTH      = 2 ** LOG2_WIDTH
);

   logic                  in_valid;
   logic                  in_ready;
   logic [WIDTH-1:0]      data_in;
   logic                  out_valid;
   logic                  out_ready;
   logic [LOG2_WIDTH-1:0] exp_out;
   logic [WIDTH-2:0]      frac_out;
   logic                  zero_out;
   logic                  sign_out;

   modport master (
      output in_valid, data_in, out_ready,
      input  in_ready, out_valid, exp_out, frac_out, zero_out, sign_out
   );

   modport slave (
      input  in_valid, data_in, out_ready,
      output in_ready, out_valid, exp_out, frac_out, zero_out, sign_out
   );

endinterface
`default_nettype wire

// File: rtl/blc_lod.sv
`default_nettype none
// ============================================================================
//  Module      : blc_lod
//  Description : Combinational priority leading-one detector.
//  Ports       : i_mag   in   WIDTH       magnitude to scan
//                o_idx   out  LOG2_WIDTH  index of the most significant 1
//                o_zero  out  1           magnitude is zero (o_idx = 0)
//  Revision    : 1.0  initial release
// ============================================================================
module blc_lod
   import blc_pkg::*;
#(
   parameter int unsigned LOG2_WIDTH = BLC_LOG2_WIDTH,
   parameter int unsigned WIDTH      = 2 ** LOG2_WIDTH
) (
   input  wire logic [WIDTH-1:0]      i_mag,
   output      logic [LOG2_WIDTH-1:0] o_idx,
   output      logic                  o_zero
);

   // Ascending scan: the highest set bit is the last one written.
   always_comb begin
      o_idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (i_mag[i]) begin
            o_idx = LOG2_WIDTH'(i);
         end
      end
   end

   assign o_zero = ~|i_mag;

endmodule
`default_nettype wire

// File: rtl/blc_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : blc_pipe
//  Description : Two-stage pipelined binary-to-logarithmic converter.
//                Stage 1 registers magnitude, sign, leading-one index and
//                zero flag; stage 2 normalizes the magnitude into a
//                left-aligned fraction. valid/ready on both sides, no skid
//                buffer: in_ready is combinational from out_ready.
//  Ports       : clk   in   rising-edge clock
//                rst   in   asynchronous active-high reset
//                bus   blc_pipe_if.slave  operand stream in, result stream out
//  Option      : BLC_SIGNED_EN  two's-complement operands, sign_out driven;
//                               undefined: unsigned operands, sign_out = 0
//  Revision    : 1.0  initial release
// ============================================================================
module blc_pipe
   import blc_pkg::*;
#(
   parameter int unsigned LOG2_WIDTH = BLC_LOG2_WIDTH,
   parameter int unsigned WIDTH      = 2 ** LOG2_WIDTH
) (
   input wire logic   clk,
   input wire logic   rst,
   blc_pipe_if.slave  bus
);

   // ---------------------------------------------------------------------
   // Stage 1 combinational front end
   // ---------------------------------------------------------------------
   logic                  w_sign;
   logic [WIDTH-1:0]      w_mag;
   logic [LOG2_WIDTH-1:0] w_lod_idx;
   logic                  w_lod_zero;

`ifdef BLC_SIGNED_EN
   // WIDTH-bit negation: the most negative value maps onto 2^(WIDTH-1),
   // which is still representable as an unsigned magnitude.
   assign w_sign = bus.data_in[WIDTH-1];
   assign w_mag  = w_sign ? (-bus.data_in) : bus.data_in;
`else
   assign w_sign = 1'b0;
   assign w_mag  = bus.data_in;
`endif

   blc_lod #(
      .LOG2_WIDTH (LOG2_WIDTH),
      .WIDTH      (WIDTH)
   ) u_lod (
      .i_mag  (w_mag),
      .o_idx  (w_lod_idx),
      .o_zero (w_lod_zero)
   );

   // ---------------------------------------------------------------------
   // Pipeline registers and flow control
   // ---------------------------------------------------------------------
   blc_stage_t            r_s1;
   logic                  r_s1_valid;
   logic                  r_s2_valid;
   logic [LOG2_WIDTH-1:0] r_exp;
   logic [WIDTH-2:0]      r_frac;
   logic                  r_zero;
   logic                  r_sign;

   logic                  w_s2_adv;
   logic                  w_s1_adv;

   assign w_s2_adv = !r_s2_valid || bus.out_ready;
   assign w_s1_adv = !r_s1_valid || w_s2_adv;

   // Held low during reset so nothing is accepted into a clearing pipe.
   assign bus.in_ready = !rst && w_s1_adv;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1       <= '0;
      end else if (w_s1_adv) begin
         r_s1_valid <= bus.in_valid;
         // An empty slot keeps its stale payload; only valid matters.
         if (bus.in_valid) begin
            r_s1.sign <= w_sign;
            r_s1.zero <= w_lod_zero;
            r_s1.exp  <= w_lod_idx;
            r_s1.mag  <= w_mag;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Stage 2: normalizing shifter
   // ---------------------------------------------------------------------
   logic [LOG2_WIDTH-1:0] w_shamt;
   logic [WIDTH-1:0]      w_norm;
   logic                  w_unused_norm_msb;

   assign w_shamt = blc_norm_shift(r_s1.exp);
   assign w_norm  = r_s1.mag << w_shamt;

   // After normalization the top bit is the hidden leading one, which the
   // anti-log side reinserts itself, so it is dropped here.
   assign w_unused_norm_msb = w_norm[WIDTH-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_exp      <= '0;
         r_frac     <= '0;
         r_zero     <= 1'b0;
         r_sign     <= 1'b0;
      end else if (w_s2_adv) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_exp  <= r_s1.zero ? '0 : r_s1.exp;
            r_frac <= r_s1.zero ? '0 : w_norm[WIDTH-2:0];
            r_zero <= r_s1.zero;
            r_sign <= r_s1.sign;
         end
      end
   end

   assign bus.out_valid = r_s2_valid;
   assign bus.exp_out   = r_exp;
   assign bus.frac_out  = r_frac;
   assign bus.zero_out  = r_zero;
   assign bus.sign_out  = r_sign;

endmodule
`default_nettype wire

// File: tb/tb_blc_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_blc_pipe
//  Description : Self-checking bench for blc_pipe (WIDTH = 16). Expected
//                results are queued when an operand is accepted and matched
//                against results captured on each output transfer.
//                Honors BLC_SIGNED_EN when defined for the build.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_blc_pipe;

   localparam int LW = 4;

   typedef struct packed {
      logic        sign;
      logic        zero;
      logic [3:0]  exp;
      logic [14:0] frac;
   } res_t;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   blc_pipe_if #(.LOG2_WIDTH(LW)) bus ();

   blc_pipe #(.LOG2_WIDTH(LW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int   n_vec = 0;
   int   n_err = 0;
   int   n_stall = 0;
   bit   rt_done;
   res_t exp_q[$];
   res_t obs_q[$];
   logic [15:0] opnd_q[$];

   // Capture every output transfer; the transfer completes at the next edge.
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready)
         obs_q.push_back({bus.sign_out, bus.zero_out, bus.exp_out, bus.frac_out});
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Present one operand until accepted; returns just after the accepting edge.
   task automatic send(input logic [15:0] d, output bit ok);
      ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.data_in  = d;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
         n_stall++;
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      if (!ok) begin
         n_vec++; n_err++;
         $display("FAIL send_timeout operand=%h not accepted within 200 cycles", d);
      end
   endtask

   task automatic wait_obs(input int n, input string tag);
      for (int c = 0; c < 500 && obs_q.size() < n; c++) @(posedge clk);
      #1;
      if (obs_q.size() < n) begin
         n_vec++; n_err++;
         $display("FAIL %s_timeout got %0d results, need %0d", tag, obs_q.size(), n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.data_in   = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (bus.out_valid !== 1'b0) begin
         n_err++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
      end
      n_vec++;
      if (bus.in_ready !== 1'b0) begin
         n_err++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready);
      end
      n_vec++;
      if ({bus.sign_out, bus.zero_out, bus.exp_out, bus.frac_out} !== 21'h0) begin
         n_err++;
         $display("FAIL reset_payload got sign=%b zero=%b exp=%0d frac=%h want all 0",
                  bus.sign_out, bus.zero_out, bus.exp_out, bus.frac_out);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_vec++;
      if (bus.in_ready !== 1'b1) begin
         n_err++; $display("FAIL release_in_ready got %b want 1", bus.in_ready);
      end
   endtask

   task automatic test_basic();
      bit   ok;
      res_t e, o;
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      e = res_t'({1'b0, 1'b0, 4'd7, 15'h3400});
      send(16'h00B4, ok);
      // One edge after acceptance the result is still in stage 1.
      @(negedge clk);
      n_vec++;
      if (bus.out_valid !== 1'b0) begin
         n_err++; $display("FAIL basic_early_valid got %b want 0", bus.out_valid);
      end
      wait_obs(1, "basic");
      if (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         n_vec++;
         if (o !== e) begin
            n_err++;
            $display("FAIL basic_00B4 got s=%b z=%b e=%0d f=%h want s=%b z=%b e=%0d f=%h",
                     o.sign, o.zero, o.exp, o.frac, e.sign, e.zero, e.exp, e.frac);
         end
      end
   endtask

   task automatic test_sweep();
      logic [15:0] ops[4];
      res_t        exps[4];
      res_t        e, o;
      bit          ok;
`ifdef BLC_SIGNED_EN
      ops[0] = 16'hFFFD; exps[0] = res_t'({1'b1, 1'b0, 4'd1,  15'h4000});
      ops[1] = 16'h8000; exps[1] = res_t'({1'b1, 1'b0, 4'd15, 15'h0000});
      ops[2] = 16'h0001; exps[2] = res_t'({1'b0, 1'b0, 4'd0,  15'h0000});
      ops[3] = 16'h0000; exps[3] = res_t'({1'b0, 1'b1, 4'd0,  15'h0000});
`else
      ops[0] = 16'h0001; exps[0] = res_t'({1'b0, 1'b0, 4'd0,  15'h0000});
      ops[1] = 16'hFFFF; exps[1] = res_t'({1'b0, 1'b0, 4'd15, 15'h7FFF});
      ops[2] = 16'h0000; exps[2] = res_t'({1'b0, 1'b1, 4'd0,  15'h0000});
      ops[3] = 16'h8000; exps[3] = res_t'({1'b0, 1'b0, 4'd15, 15'h0000});
`endif
      bus.out_ready = 1'b1;
      n_stall = 0;
      for (int i = 0; i < 4; i++) begin
         send(ops[i], ok);
         if (ok) exp_q.push_back(exps[i]);
      end
      // Back-to-back with out_ready high: every operand taken on first offer.
      n_vec++;
      if (n_stall !== 0) begin
         n_err++; $display("FAIL back_to_back_stalls got %0d want 0", n_stall);
      end
      wait_obs(4, "sweep");
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_vec++;
         if (obs_q.size() == 0) begin
            n_err++; $display("FAIL sweep_missing got none want e=%0d f=%h", e.exp, e.frac);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_err++;
               $display("FAIL sweep got s=%b z=%b e=%0d f=%h want s=%b z=%b e=%0d f=%h",
                        o.sign, o.zero, o.exp, o.frac, e.sign, e.zero, e.exp, e.frac);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] ops[4];
      res_t        exps[4];
      res_t        e, o, cur, snap;
      bit          have_snap, took, ok;
      int          idx, acc;
      ops[0] = 16'h0003; exps[0] = res_t'({1'b0, 1'b0, 4'd1,  15'h4000});
      ops[1] = 16'h0100; exps[1] = res_t'({1'b0, 1'b0, 4'd8,  15'h0000});
      ops[2] = 16'h7FFF; exps[2] = res_t'({1'b0, 1'b0, 4'd14, 15'h7FFE});
      ops[3] = 16'h0040; exps[3] = res_t'({1'b0, 1'b0, 4'd6,  15'h0000});
      idx = 0; acc = 0; have_snap = 1'b0; snap = '0;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.data_in   = ops[0];
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            cur = {bus.sign_out, bus.zero_out, bus.exp_out, bus.frac_out};
            if (!have_snap) begin
               snap = cur; have_snap = 1'b1;
            end else begin
               n_vec++;
               if (cur !== snap) begin
                  n_err++; $display("FAIL stall_stable got e=%0d f=%h want e=%0d f=%h",
                                    cur.exp, cur.frac, snap.exp, snap.frac);
               end
            end
         end
         took = bus.in_valid && bus.in_ready;
         @(posedge clk); #1;
         if (took) begin
            exp_q.push_back(exps[idx]);
            idx++; acc++;
            if (idx < 4) bus.data_in = ops[idx];
            else         bus.in_valid = 1'b0;
         end
      end
      @(negedge clk);
      n_vec++;
      if (acc !== 2) begin
         n_err++; $display("FAIL stall_accepts got %0d want 2", acc);
      end
      n_vec++;
      if (bus.in_ready !== 1'b0) begin
         n_err++; $display("FAIL stall_in_ready got %b want 0", bus.in_ready);
      end
      n_vec++;
      if (obs_q.size() !== 0) begin
         n_err++; $display("FAIL stall_leak got %0d results want 0", obs_q.size());
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      while (idx < 4) begin
         send(ops[idx], ok);
         if (ok) exp_q.push_back(exps[idx]);
         idx++;
      end
      wait_obs(4, "bp");
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_vec++;
         if (obs_q.size() == 0) begin
            n_err++; $display("FAIL bp_missing got none want e=%0d f=%h", e.exp, e.frac);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_err++;
               $display("FAIL bp_order got e=%0d f=%h want e=%0d f=%h",
                        o.exp, o.frac, e.exp, e.frac);
            end
         end
      end
      repeat (3) @(posedge clk); #1;
      n_vec++;
      if (obs_q.size() !== 0) begin
         n_err++; $display("FAIL bp_duplicate got %0d extra results want 0", obs_q.size());
      end
   endtask

   task automatic test_reset_midstream();
      bit ok;
      bus.out_ready = 1'b0;
      send(16'h1234, ok);
      send(16'h0055, ok);
      @(negedge clk);
      n_vec++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
         n_err++; $display("FAIL midrst_full got valid=%b ready=%b want valid=1 ready=0",
                           bus.out_valid, bus.in_ready);
      end
      rst = 1'b1;
      #1;
      n_vec++;
      if (bus.out_valid !== 1'b0) begin
         n_err++; $display("FAIL midrst_async got out_valid=%b want 0", bus.out_valid);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      bus.out_ready = 1'b1;
      repeat (5) @(posedge clk); #1;
      n_vec++;
      if (obs_q.size() !== 0 || bus.out_valid !== 1'b0) begin
         n_err++; $display("FAIL midrst_stale got %0d results valid=%b want 0 and 0",
                           obs_q.size(), bus.out_valid);
      end
   endtask

   task automatic test_roundtrip();
      logic [15:0] d, mag, hid, rec;
      logic        esign;
      res_t        o;
      bit          ok, bad;
      rt_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               d = 16'($urandom);
               if (i % 50 == 0) d = 16'h0000;
               if (i % 50 == 1) d = 16'h8000;
               if (i % 50 == 2) d = 16'($urandom_range(0, 255));
               send(d, ok);
               if (ok) opnd_q.push_back(d);
            end
            rt_done = 1'b1;
         end
         begin
            while (!rt_done) begin
               @(posedge clk); #1;
               bus.out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      bus.out_ready = 1'b1;
      wait_obs(opnd_q.size(), "roundtrip");
      while (opnd_q.size() > 0) begin
         d = opnd_q.pop_front();
`ifdef BLC_SIGNED_EN
         esign = d[15];
         mag   = d[15] ? (16'h0 - d) : d;
`else
         esign = 1'b0;
         mag   = d;
`endif
         n_vec++;
         if (obs_q.size() == 0) begin
            n_err++; $display("FAIL rt_missing operand=%h got none", d);
         end else begin
            o   = obs_q.pop_front();
            hid = {1'b1, o.frac};
            rec = hid >> (4'd15 - o.exp);
            bad = (o.sign !== esign) || (o.zero !== (mag == 16'h0));
            if (mag != 16'h0) bad = bad || (rec !== mag);
            else              bad = bad || (o.exp !== 4'd0) || (o.frac !== 15'h0);
            if (bad) begin
               n_err++;
               $display("FAIL rt operand=%h got s=%b z=%b e=%0d f=%h rec=%h want mag=%h s=%b",
                        d, o.sign, o.zero, o.exp, o.frac, rec, mag, esign);
            end
         end
      end
      n_vec++;
      if (obs_q.size() !== 0) begin
         n_err++; $display("FAIL rt_extra got %0d extra results want 0", obs_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_sweep();
      test_backpressure();
      test_reset_midstream();
      test_roundtrip();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/blc_pipe.md
# blc_pipe

Pipelined binary-to-logarithmic converter (BLC) for the approximate log-multiplier datapath. Each WIDTH-bit operand becomes a leading-one exponent and a left-aligned fraction; the pair sits upstream of the exponent adder and the anti-log converter (LBC). Fraction and exponent formats match what LBC consumes, so BLC → exponent add → LBC closes the log-multiply loop. Two registered stages with valid/ready backpressure on both sides.

## Interface
Parameters:
- LOG2_WIDTH, 4, log2 of operand width
- WIDTH, 2**LOG2_WIDTH, operand width in bits

Ports:
- Clock and reset: one clock, `clk`; reset `rst` is asynchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  reset
- in_valid  in  1  operand valid
- in_ready  out  1  stage 1 can accept
- data_in  in  WIDTH  operand (unsigned; two's complement with BLC_SIGNED_EN)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- exp_out  out  LOG2_WIDTH  bit index of leading one of magnitude
- frac_out  out  WIDTH-1  bits below leading one, left-aligned (MSB = bit just under the leading one)
- zero_out  out  1  magnitude was zero
- sign_out  out  1  operand sign (0 without BLC_SIGNED_EN)

## Operation
- Transfer occurs on a cycle where valid and ready are both high, on either side.
- Stage 1 registers:
  - magnitude (|data_in| if signed, else data_in)
  - sign
  - leading-one index E from the leading-one detector
  - zero flag (magnitude == 0)
- Stage 2 registers:
  - exp_out = E
  - frac_out = (mag << (WIDTH-1-E))[WIDTH-2:0]
  - zero_out, sign_out
- Zero magnitude forces exp_out = 0 and frac_out = 0, with zero_out = 1. Downstream uses zero_out to force a zero product, because LBC always reinserts the hidden 1.
- Exact conversion: the magnitude is recoverable as {1, frac_out} >> (WIDTH-1-exp_out). No rounding, no truncation.
- Backpressure:
  - Stage 2 advances when !out_valid || out_ready.
  - Stage 1 advances when it is empty or stage 2 advances.
  - in_ready = !s1_valid || s2_advance, combinational from out_ready. There is no skid buffer.
- Full: both stages hold data and out_ready = 0. Then in_ready = 0, and all registers hold.
- Simultaneous accept at input and output on the same cycle: throughput stays 1 per cycle, with no bubble.
- Output payload is stable while out_valid && !out_ready.
- Empty stage registers keep their old payload; only the valid bits are meaningful.

## Timing
- Latency: an operand accepted at edge N appears as out_valid at edge N+2 when out_ready is held high.
- Throughput: 1 operand per cycle.
- Reset (asynchronous, immediate):
  - s1_valid = 0, out_valid = 0
  - exp_out, frac_out, zero_out, sign_out = 0
  - in_ready = 0 while rst is high, and 1 on the first cycle after release
- Reset mid-operation discards all in-flight operands. No output is produced for them.
- No combinational path from data_in to any output.

## Configuration
- BLC_SIGNED_EN defined:
  - data_in is two's complement and sign_out = data_in[WIDTH-1].
  - Magnitude is taken with WIDTH bits, so -2^(WIDTH-1) yields mag = 2^(WIDTH-1), exp_out = WIDTH-1, frac_out = 0.
- BLC_SIGNED_EN undefined:
  - data_in is unsigned and sign_out is tied 0.
  - No negation logic is built.

## Structure
- Package blc_pkg holds:
  - localparams FRAC_W = WIDTH-1 and EXP_W = LOG2_WIDTH
  - a packed struct for the stage payload {sign, zero, exp, mag}
  - shared with the LBC-side exponent adder
- Sub-module blc_lod: combinational priority leading-one detector.
  - Inputs: WIDTH-bit magnitude.
  - Outputs: LOG2_WIDTH-bit index and a zero flag.
  - Instantiated once in stage 1.
- The normalizing shifter stays inline in stage 2.

## Test plan
All scenarios use WIDTH=16.
- Reset, then data_in=0x00B4 with out_ready=1 → two cycles later: exp_out=7, frac_out=0x3400, zero_out=0.
- Unsigned sweep: 0x0001 → exp 0, frac 0x0000; 0xFFFF → exp 15, frac 0x7FFF; 0x0000 → zero_out=1, exp 0, frac 0.
- BLC_SIGNED_EN: 0xFFFD → sign 1, exp 1, frac 0x4000; 0x8000 → sign 1, exp 15, frac 0x0000.
- Backpressure: stream 4 operands with out_ready=0 for 5 cycles. Expect:
  - in_ready falls after 2 accepts
  - outputs stay stable while stalled
  - all 4 results arrive in order once out_ready=1, with no loss or duplication
- Reset mid-stream: assert rst with both stages full → out_valid drops immediately; no stale result after release.
- Round-trip: 1000 random operands fed through blc_pipe, then into LBC with exp_sum=exp_out → LBC result equals the operand magnitude for every nonzero operand.
